// File: rtl/pong_match_ctrl.sv
// Match sequencer for the paddle/ball game: phase FSM, score/lives/combo/level
// bookkeeping and the ball-move strobe whose period shrinks with speed level.
module pong_match_ctrl #(
    parameter int SERVE_DELAY     = 25000000,
    parameter int BASE_PERIOD     = 500000,
    parameter int STEP            = 50000,
    parameter int MIN_PERIOD      = 50000,
    parameter int LIVES           = 3,
    parameter int COMBO_PER_LEVEL = 5,
    parameter int LEVEL_MAX       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic        miss,
    output logic [2:0]  state,
    output logic        play_en,
    output logic        ball_reset,
    output logic        move_tick,
    output logic [19:0] period,
    output logic [3:0]  level,
    output logic [7:0]  combo,
    output logic [7:0]  score,
    output logic [2:0]  lives,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int SW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_DELAY - 1);

    state_t         state_reg, state_next;
    logic [SW-1:0]  serve_reg, serve_next;
    logic [19:0]    tick_reg, tick_next;
    logic [19:0]    period_reg, period_next;
    logic [3:0]     level_reg, level_next;
    logic [7:0]     combo_reg, combo_next;
    logic [7:0]     score_reg, score_next;
    logic [2:0]     lives_reg, lives_next;
    logic           play_en_reg, play_en_next;
    logic           ball_reset_reg, ball_reset_next;
    logic           move_tick_reg, move_tick_next;
    logic           game_over_reg, game_over_next;

    logic           tick_wrap;
    logic [19:0]    tick_adv;
    logic [7:0]     combo_inc;

    // Underflow of BASE - level*STEP clamps to the floor rather than wrapping.
    function automatic logic [19:0] calc_period(input logic [3:0] lvl);
        logic [23:0] base;
        logic [23:0] dec;
        base = 24'(BASE_PERIOD);
        dec  = 24'(lvl) * 24'(STEP);
        if (dec >= base)
            return 20'(MIN_PERIOD);
        if ((base - dec) < 24'(MIN_PERIOD))
            return 20'(MIN_PERIOD);
        return 20'(base - dec);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            serve_reg      <= '0;
            tick_reg       <= '0;
            period_reg     <= 20'(BASE_PERIOD);
            level_reg      <= '0;
            combo_reg      <= '0;
            score_reg      <= '0;
            lives_reg      <= '0;
            play_en_reg    <= 1'b0;
            ball_reset_reg <= 1'b0;
            move_tick_reg  <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            serve_reg      <= serve_next;
            tick_reg       <= tick_next;
            period_reg     <= period_next;
            level_reg      <= level_next;
            combo_reg      <= combo_next;
            score_reg      <= score_next;
            lives_reg      <= lives_next;
            play_en_reg    <= play_en_next;
            ball_reset_reg <= ball_reset_next;
            move_tick_reg  <= move_tick_next;
            game_over_reg  <= game_over_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        serve_next      = serve_reg;
        tick_next       = tick_reg;
        level_next      = level_reg;
        combo_next      = combo_reg;
        score_next      = score_reg;
        lives_next      = lives_reg;
        ball_reset_next = 1'b0;
        move_tick_next  = 1'b0;

        tick_wrap = (tick_reg >= period_reg - 20'd1);
        tick_adv  = tick_wrap ? 20'd0 : tick_reg + 20'd1;
        combo_inc = (combo_reg == 8'hFF) ? combo_reg : combo_reg + 8'd1;

        case (state_reg)
            IDLE, OVER: begin
                if (start) begin
                    state_next      = SERVE;
                    lives_next      = 3'(LIVES);
                    score_next      = '0;
                    combo_next      = '0;
                    level_next      = '0;
                    serve_next      = SERVE_LOAD;
                    ball_reset_next = 1'b1;
                end
            end
            SERVE: begin
                if (serve_reg == '0) begin
                    state_next = PLAY;
                    tick_next  = '0;
                end else begin
                    serve_next = serve_reg - 1'b1;
                end
            end
            PLAY: begin
                // miss beats hit, and either beats pause in the same cycle
                if (miss) begin
                    combo_next = '0;
                    level_next = '0;
                    tick_next  = '0;
                    if (lives_reg <= 3'd1) begin
                        lives_next = '0;
                        state_next = OVER;
                    end else begin
                        lives_next      = lives_reg - 3'd1;
                        state_next      = SERVE;
                        serve_next      = SERVE_LOAD;
                        ball_reset_next = 1'b1;
                    end
                end else if (hit) begin
                    score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                    combo_next = combo_inc;
                    if ((combo_inc != 8'd0) &&
                        ((32'(combo_inc) % 32'(COMBO_PER_LEVEL)) == 32'd0) &&
                        (level_reg < 4'(LEVEL_MAX))) begin
                        level_next = level_reg + 4'd1;
                        tick_next  = '0;
                    end else begin
                        tick_next      = tick_adv;
                        move_tick_next = tick_wrap;
                    end
                end else if (pause) begin
                    state_next = PAUSE;
                end else begin
                    tick_next      = tick_adv;
                    move_tick_next = tick_wrap;
                end
            end
            PAUSE: begin
                if (pause)
                    state_next = PLAY;
            end
            default: state_next = IDLE;
        endcase
    end

    assign period_next    = calc_period(level_next);
    assign play_en_next   = (state_next == PLAY);
    assign game_over_next = (state_next == OVER);

    assign state      = state_reg;
    assign play_en    = play_en_reg;
    assign ball_reset = ball_reset_reg;
    assign move_tick  = move_tick_reg;
    assign period     = period_reg;
    assign level      = level_reg;
    assign combo      = combo_reg;
    assign score      = score_reg;
    assign lives      = lives_reg;
    assign game_over  = game_over_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small timing parameters; expected
// values are hand-derived constants.
module tb_pong_match_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, pause, hit, miss;
    logic [2:0]  state;
    logic        play_en, ball_reset, move_tick, game_over;
    logic [19:0] period;
    logic [3:0]  level;
    logic [7:0]  combo, score;
    logic [2:0]  lives;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int tick_seen;

    pong_match_ctrl #(
        .SERVE_DELAY(4), .BASE_PERIOD(10), .STEP(2), .MIN_PERIOD(3),
        .LIVES(2), .COMBO_PER_LEVEL(2), .LEVEL_MAX(9)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit), .miss(miss),
        .state(state), .play_en(play_en), .ball_reset(ball_reset), .move_tick(move_tick),
        .period(period), .level(level), .combo(combo), .score(score), .lives(lives),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until move_tick is seen; -1 if it never comes within the budget.
    task automatic wait_tick(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (move_tick) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; pause = 0; hit = 0; miss = 0;
        #3;
        check("rst_state", 32'(state), 0);
        check("rst_period", 32'(period), 10);
        check("rst_lives", 32'(lives), 0);
        check("rst_play_en", 32'(play_en), 0);
        step(); step();
        rst = 1'b0;
        step();

        // match start and serve
        start = 1; step(); start = 0;
        check("start_state", 32'(state), 1);
        check("start_ball_reset", 32'(ball_reset), 1);
        check("start_lives", 32'(lives), 2);
        step();
        check("ball_reset_1cyc", 32'(ball_reset), 0);
        step(); step();
        check("serve_cyc4", 32'(state), 1);
        step();
        check("play_entry", 32'(state), 2);
        check("play_en", 32'(play_en), 1);
        wait_tick(n);
        check("first_tick_gap", n, 10);
        wait_tick(n);
        check("tick_spacing_l0", n, 10);

        // hits and speed-up
        hit = 1; step(); hit = 0;
        check("hit1_combo", 32'(combo), 1);
        check("hit1_level", 32'(level), 0);
        hit = 1; step(); hit = 0;
        check("hit2_combo", 32'(combo), 2);
        check("hit2_level", 32'(level), 1);
        step();
        check("period_l1", 32'(period), 8);
        wait_tick(n);
        check("tick_after_lvl", n, 7);
        wait_tick(n);
        check("tick_spacing_l1", n, 8);
        for (int i = 0; i < 8; i++) begin
            hit = 1; step(); hit = 0;
        end
        check("hit10_combo", 32'(combo), 10);
        check("hit10_level", 32'(level), 5);
        step();
        check("period_clamp_l5", 32'(period), 3);
        hit = 1; step(); step(); hit = 0;
        check("level6", 32'(level), 6);
        step();
        check("period_clamp_l6", 32'(period), 3);
        wait_tick(n);
        wait_tick(n);
        check("tick_spacing_min", n, 3);
        check("score12", 32'(score), 12);

        // first miss
        miss = 1; step(); miss = 0;
        check("miss_lives", 32'(lives), 1);
        check("miss_combo", 32'(combo), 0);
        check("miss_level", 32'(level), 0);
        check("miss_state", 32'(state), 1);
        check("miss_ball_reset", 32'(ball_reset), 1);
        check("miss_play_en", 32'(play_en), 0);
        step();
        check("miss_period", 32'(period), 10);
        step(); step();
        check("reserve_cyc4", 32'(state), 1);
        step();
        check("reserve_play", 32'(state), 2);

        // hit+miss together on last life
        hit = 1; miss = 1; step(); hit = 0; miss = 0;
        check("hm_score", 32'(score), 12);
        check("over_lives", 32'(lives), 0);
        check("over_state", 32'(state), 4);
        check("over_game_over", 32'(game_over), 1);

        // restart from OVER; start and hit ignored in SERVE
        start = 1; step(); start = 0;
        check("restart_state", 32'(state), 1);
        check("restart_lives", 32'(lives), 2);
        check("restart_score", 32'(score), 0);
        check("restart_game_over", 32'(game_over), 0);
        start = 1; step(); start = 0;
        check("start_in_serve_ball_reset", 32'(ball_reset), 0);
        hit = 1; step(); hit = 0;
        check("hit_in_serve", 32'(score), 0);
        step();
        check("serve_not_restarted", 32'(state), 1);
        step();
        check("play_again", 32'(state), 2);

        // pause at tick counter 6
        wait_tick(n);
        check("first_tick_gap2", n, 10);
        repeat (6) step();
        pause = 1; step(); pause = 0;
        check("pause_state", 32'(state), 3);
        check("pause_play_en", 32'(play_en), 0);
        tick_seen = 0;
        for (int i = 0; i < 20; i++) begin
            hit  = (i == 5);
            miss = (i == 9);
            step();
            if (move_tick) tick_seen++;
        end
        hit = 0; miss = 0;
        check("pause_no_tick", tick_seen, 0);
        check("pause_hit_ignored", 32'(score), 0);
        check("pause_miss_ignored", 32'(lives), 2);
        pause = 1; step(); pause = 0;
        check("resume_state", 32'(state), 2);
        wait_tick(n);
        check("resume_tick_gap", n, 4);

        // pause with hit: hit wins, pause dropped
        hit = 1; pause = 1; step(); hit = 0; pause = 0;
        check("hit_pause_state", 32'(state), 2);
        check("hit_pause_score", 32'(score), 1);

        // asynchronous reset mid-PLAY
        rst = 1;
        #2;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_score", 32'(score), 0);
        check("async_rst_combo", 32'(combo), 0);
        check("async_rst_play_en", 32'(play_en), 0);
        step();
        rst = 0;
        step();
        check("idle_after_rst", 32'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
